// File: rtl/package_serializer_pkg.sv
// Shared constants and state encoding for the window-to-package serializer.
package package_serializer_pkg;

  localparam logic [7:0]  START_BYTE   = 8'h55;
  localparam logic [7:0]  FUNC_BASE    = 8'h51;
  localparam int unsigned PACKAGE_SIZE = 11;
  localparam int unsigned PACKAGE_NUM  = 4;

  // Byte positions inside one package; data bytes sit between FUNC and SUM.
  localparam int unsigned BYTE_START = 0;
  localparam int unsigned BYTE_FUNC  = 1;
  localparam int unsigned BYTE_SUM   = 10;

  typedef enum logic [0:0] {
    StIdle,
    StSend
  } state_e;

endpackage

// File: rtl/package_checksum_acc.sv
// 8-bit modulo-256 accumulator used to build the per-package checksum.
module package_checksum_acc (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       add_en_i,
  input  logic [7:0] byte_i,
  output logic [7:0] sum_o
);

  logic [7:0] sum_q;

  // Clear has priority over add so a package boundary always starts from zero.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      sum_q <= 8'h00;
    end else if (add_en_i) begin
      sum_q <= sum_q + byte_i;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/package_serializer.sv
// Splits a captured window into fixed-size packages (start, func, data, checksum)
// and streams them byte by byte into a ready/valid request FIFO.
module package_serializer #(
  parameter int unsigned WINDOW_WIDTH = 256,
  parameter int unsigned PACKAGE_SIZE = package_serializer_pkg::PACKAGE_SIZE,
  parameter int unsigned PACKAGE_NUM  = package_serializer_pkg::PACKAGE_NUM,
  parameter logic [7:0]  START_BYTE   = package_serializer_pkg::START_BYTE,
  parameter logic [7:0]  FUNC_BASE    = package_serializer_pkg::FUNC_BASE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WINDOW_WIDTH-1:0] data_i,
  input  logic                    data_vld,
  output logic                    data_rdy,
  output logic [7:0]              fifo_data_o,
  output logic                    fifo_data_vld,
  input  logic                    fifo_data_rdy,
  output logic                    busy,
  output logic                    done
);

  import package_serializer_pkg::*;

  localparam int unsigned DataPerPkg = PACKAGE_SIZE - 3;
  localparam int unsigned ByteW = (PACKAGE_SIZE > 1) ? $clog2(PACKAGE_SIZE) : 1;
  localparam int unsigned PkgW  = (PACKAGE_NUM > 1) ? $clog2(PACKAGE_NUM) : 1;

  if (WINDOW_WIDTH != PACKAGE_NUM * DataPerPkg * 8) begin : g_width_check
    $error("WINDOW_WIDTH must equal PACKAGE_NUM*(PACKAGE_SIZE-3)*8");
  end

  state_e                  state_q, state_d;
  logic [ByteW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [PkgW-1:0]         pkg_cnt_q, pkg_cnt_d;
  logic [WINDOW_WIDTH-1:0] capture_q;
  logic                    done_q, done_d;
  logic                    accept, fire, last_byte, last_pkg;
  logic                    sum_clr, sum_add;
  logic [7:0]              sum, tx_byte;

  assign accept    = (state_q == StIdle) && data_vld;
  assign fire      = (state_q == StSend) && fifo_data_rdy;
  assign last_byte = (byte_cnt_q == ByteW'(PACKAGE_SIZE - 1));
  assign last_pkg  = (pkg_cnt_q == PkgW'(PACKAGE_NUM - 1));

  // Next-state logic: counters advance only when the FIFO takes the current byte.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    pkg_cnt_d  = pkg_cnt_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (data_vld) begin
          state_d    = StSend;
          byte_cnt_d = '0;
          pkg_cnt_d  = '0;
        end
      end
      StSend: begin
        if (fifo_data_rdy) begin
          if (last_byte) begin
            byte_cnt_d = '0;
            if (last_pkg) begin
              state_d   = StIdle;
              pkg_cnt_d = '0;
              done_d    = 1'b1;
            end else begin
              pkg_cnt_d = pkg_cnt_q + 1'b1;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counters and window capture; reset aborts any window in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      byte_cnt_q <= '0;
      pkg_cnt_q  <= '0;
      capture_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      pkg_cnt_q  <= pkg_cnt_d;
      done_q     <= done_d;
      if (accept) begin
        capture_q <= data_i;
      end
    end
  end

  // Checksum restarts on window accept and after each package's final byte.
  assign sum_clr = accept || (fire && last_byte);
  assign sum_add = fire && !last_byte;

  package_checksum_acc u_checksum (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (sum_clr),
    .add_en_i (sum_add),
    .byte_i   (tx_byte),
    .sum_o    (sum)
  );

  // Byte mux: purely from registered state, so no path from either ready/valid input.
  always_comb begin
    int unsigned             idx;
    logic [WINDOW_WIDTH-1:0] shifted;
    tx_byte = 8'h00;
    idx     = 0;
    shifted = '0;
    if (state_q == StSend) begin
      if (byte_cnt_q == ByteW'(BYTE_START)) begin
        tx_byte = START_BYTE;
      end else if (byte_cnt_q == ByteW'(BYTE_FUNC)) begin
        tx_byte = FUNC_BASE + 8'(pkg_cnt_q);
      end else if (last_byte) begin
        tx_byte = sum;
      end else begin
        // Window byte 0 is the MSB byte, so shift it up to the top and take it.
        idx     = 32'(pkg_cnt_q) * DataPerPkg + 32'(byte_cnt_q) - 32'd2;
        shifted = capture_q << (8 * idx);
        tx_byte = shifted[WINDOW_WIDTH-1 -: 8];
      end
    end
  end

  assign fifo_data_o   = tx_byte;
  assign fifo_data_vld = (state_q == StSend);
  assign busy          = (state_q == StSend);
  assign data_rdy      = (state_q == StIdle);
  assign done          = done_q;

endmodule

// File: doc/package_serializer.md
PACKAGE_SERIALIZER -- requirements
Module: package_serializer

Interface
REQ-001 SHALL have parameter WINDOW_WIDTH, default 256, the width of one window in bits (32 B).
REQ-002 SHALL have parameter PACKAGE_SIZE, default 11, bytes per package: start, func, 8 data, checksum.
REQ-003 SHALL have parameter PACKAGE_NUM, default 4, packages per window.
REQ-004 SHALL have parameter START_BYTE, default 8'h55, the package start marker.
REQ-005 SHALL have parameter FUNC_BASE, default 8'h51, the function code of package 0.
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-008 SHALL have port data_i, input, WINDOW_WIDTH, the window to transmit; byte 0 is data_i[255:248].
REQ-009 SHALL have port data_vld, input, 1, data_i is valid.
REQ-010 SHALL have port data_rdy, output, 1, the block accepts a window.
REQ-011 SHALL have port fifo_data_o, output, 8, the byte to the BlueTooth request FIFO.
REQ-012 SHALL have port fifo_data_vld, output, 1, fifo_data_o is valid.
REQ-013 SHALL have port fifo_data_rdy, input, 1, the request FIFO accepts the byte.
REQ-014 SHALL have ports busy (1, high while not IDLE) and done (1, one-cycle pulse after the last byte is accepted), both outputs.

Function
REQ-015 SHALL implement the FSM states IDLE and SEND.
- IDLE -> SEND on data_vld and data_rdy.
- SEND -> IDLE when the last byte of the last package is accepted.
REQ-016 SHALL drive data_rdy=1 only in IDLE, and SHALL register data_i into a capture register on acceptance.
REQ-017 SHALL assert fifo_data_vld in the cycle after acceptance, with the first byte equal to START_BYTE.
REQ-018 SHALL transmit, for package p (0..PACKAGE_NUM-1), these bytes in order:
- START_BYTE;
- FUNC_BASE+p;
- window bytes 8p..8p+7;
- a checksum equal to the sum of the package's first 10 bytes, modulo 256, with the carry discarded.
REQ-019 SHALL advance a byte only on fifo_data_vld && fifo_data_rdy; while fifo_data_rdy=0, fifo_data_o and fifo_data_vld SHALL hold stable.
REQ-020 SHALL have no combinational path from fifo_data_rdy or data_vld to any output.
REQ-021 SHALL keep a byte counter (0..PACKAGE_SIZE-1) and a package counter (0..PACKAGE_NUM-1).
- Byte counter wraps to 0 after PACKAGE_SIZE-1 and increments the package counter.
- Checksum accumulator clears at each package start.
REQ-022 SHALL, with fifo_data_rdy held high, emit 44 bytes in 44 consecutive cycles.
REQ-023 SHALL pulse done and return data_rdy=1 in the cycle after the final byte is accepted, giving a minimum window period of 45 cycles.
REQ-024 SHALL ignore data_vld while in SEND; the window is neither lost upstream nor overwritten.
REQ-025 SHALL require WINDOW_WIDTH == PACKAGE_NUM*(PACKAGE_SIZE-3)*8, checked at elaboration.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, set:
- state to IDLE;
- both counters, the checksum and the capture register to 0;
- fifo_data_vld=0, fifo_data_o=8'h00, done=0, busy=0;
- data_rdy=1 from the first cycle after rst deasserts.
REQ-027 SHALL abort any in-flight window when rst asserts mid-transmission, with no partial resume; the next window restarts at package 0.

Structure
REQ-028 SHALL place in a shared package: START_BYTE, FUNC_BASE, PACKAGE_SIZE, PACKAGE_NUM, the state encoding, and the byte-index constants (START=0, FUNC=1, SUM=10).
REQ-029 SHALL use one sub-module, package_checksum_acc: an 8-bit accumulator with clear, add-enable and byte input.

Verification
REQ-030 Window bytes 0x00..0x1F, fifo_data_rdy=1 -> 44 bytes in 44 cycles:
- package 0 = 55 51 00..07 C2;
- package 1 = 55 52 08..0F 03;
- done pulses once.
REQ-031 Window of all 0xFF -> package 0 checksum = 0x9E (carry discarded); all four function codes are 51/52/53/54.
REQ-032 Drop fifo_data_rdy for 5 cycles while byte 3 is presented -> byte 3 is held stable, the total stays 44 bytes, and no byte is duplicated or skipped.
REQ-033 Assert rst for 1 cycle after 20 accepted bytes -> fifo_data_vld=0 the next cycle, then data_rdy=1; the next window starts 55 51.
REQ-034 data_vld held high with two windows queued -> the second window is accepted in the cycle after done, and 88 bytes are emitted in total.
